// File: rtl/sha1_check.sv
// sha1_check: sequential SHA-1 digest verifier.
// Recomputes SHA-1 of a 32-bit message one round per cycle and compares it to a streamed digest.
module sha1_check (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic [31:0]  msg_i,
  input  logic         msg_valid_i,
  output logic         msg_ready_o,
  input  logic [31:0]  dig_i,
  input  logic         dig_valid_i,
  output logic         dig_ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         match_o,
  output logic [159:0] digest_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_ROUND,
    S_FIN
  } state_t;

  localparam logic [31:0] H0 = 32'h67452301;
  localparam logic [31:0] H1 = 32'hEFCDAB89;
  localparam logic [31:0] H2 = 32'h98BADCFE;
  localparam logic [31:0] H3 = 32'h10325476;
  localparam logic [31:0] H4 = 32'hC3D2E1F0;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_msg;
  logic [2:0]    r_cnt;
  logic [159:0]  r_slot;
  logic [6:0]    r_t;
  logic [31:0]   r_a, r_b, r_c, r_d, r_e;
  logic [31:0]   r_w [16];
  logic [159:0]  r_digest;
  logic          r_match;
  logic          r_done;

  logic          w_msg_xfer;
  logic          w_dig_xfer;
  logic [31:0]   w_x;
  logic [31:0]   w_fresh;
  logic [31:0]   w_wt;
  logic [31:0]   w_f;
  logic [31:0]   w_k;
  logic [31:0]   w_tmp;
  logic [159:0]  w_sum;

  // Readies come from registered state; clear/reset force them low.
  assign msg_ready_o = (r_state == S_IDLE) & ~rst & ~clear_i;
  assign dig_ready_o = (r_state == S_COLLECT) & ~rst & ~clear_i;
  assign busy_o      = ((r_state == S_COLLECT) | (r_state == S_ROUND)) & ~rst;
  assign done_o      = r_done & ~rst;
  assign match_o     = r_match & ~rst;
  assign digest_o    = rst ? 160'd0 : r_digest;

  assign w_msg_xfer = msg_valid_i & msg_ready_o;
  assign w_dig_xfer = dig_valid_i & dig_ready_o;

  // Window holds W[t..t+15] while t<16 (rotated), then W[t-16..t-1].
  assign w_x     = r_w[13] ^ r_w[8] ^ r_w[2] ^ r_w[0];
  assign w_fresh = {w_x[30:0], w_x[31]};
  assign w_wt    = (r_t < 7'd16) ? r_w[0] : w_fresh;

  assign w_sum = {H0 + r_a, H1 + r_b, H2 + r_c, H3 + r_d, H4 + r_e};

  // Round function and constant selected by round index.
  always_comb begin
    w_f = r_b ^ r_c ^ r_d;
    w_k = 32'hCA62C1D6;
    if (r_t < 7'd20) begin
      w_f = (r_b & r_c) | (~r_b & r_d);
      w_k = 32'h5A827999;
    end else if (r_t < 7'd40) begin
      w_k = 32'h6ED9EBA1;
    end else if (r_t < 7'd60) begin
      w_f = (r_b & r_c) | (r_b & r_d) | (r_c & r_d);
      w_k = 32'h8F1BBCDC;
    end
  end

  assign w_tmp = {r_a[26:0], r_a[31:27]} + w_f + r_e + w_k + w_wt;

  // Next-state decode; clear outranks everything.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_msg_xfer) w_next = S_COLLECT;
      S_COLLECT: if (w_dig_xfer && r_cnt == 3'd4) w_next = S_ROUND;
      S_ROUND:   if (r_t == 7'd79) w_next = S_FIN;
      S_FIN:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (clear_i) w_next = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: capture, digest collection, rounds and final compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_msg    <= '0;
      r_cnt    <= '0;
      r_slot   <= '0;
      r_t      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_e      <= '0;
      r_digest <= '0;
      r_match  <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else if (clear_i) begin
      r_cnt   <= '0;
      r_t     <= '0;
      r_match <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_msg_xfer) begin
            r_msg    <= msg_i;
            r_match  <= 1'b0;
            r_digest <= '0;
            r_cnt    <= '0;
          end
        end
        S_COLLECT: begin
          if (w_dig_xfer) begin
            r_slot <= {r_slot[127:0], dig_i};
            r_cnt  <= r_cnt + 3'd1;
            if (r_cnt == 3'd4) begin
              r_t <= '0;
              r_a <= H0;
              r_b <= H1;
              r_c <= H2;
              r_d <= H3;
              r_e <= H4;
              r_w[0] <= r_msg;
              r_w[1] <= 32'h80000000;
              for (int i = 2; i < 15; i++) r_w[i] <= '0;
              r_w[15] <= 32'h00000020;
            end
          end
        end
        S_ROUND: begin
          r_e <= r_d;
          r_d <= r_c;
          r_c <= {r_b[1:0], r_b[31:2]};
          r_b <= r_a;
          r_a <= w_tmp;
          r_t <= r_t + 7'd1;
          for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
          r_w[15] <= (r_t < 7'd16) ? r_w[0] : w_fresh;
        end
        S_FIN: begin
          r_digest <= w_sum;
          r_match  <= (w_sum == r_slot);
          r_done   <= 1'b1;
          r_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_check.sv
// tb_sha1_check: scoreboard bench for sha1_check.
// Directed transactions push expectations; a negedge monitor checks each done pulse.
module tb_sha1_check;

  logic         clk;
  logic         rst;
  logic         clear_i;
  logic [31:0]  msg_i;
  logic         msg_valid_i;
  logic         msg_ready_o;
  logic [31:0]  dig_i;
  logic         dig_valid_i;
  logic         dig_ready_o;
  logic         busy_o;
  logic         done_o;
  logic         match_o;
  logic [159:0] digest_o;

  sha1_check dut (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_i),
    .msg_i       (msg_i),
    .msg_valid_i (msg_valid_i),
    .msg_ready_o (msg_ready_o),
    .dig_i       (dig_i),
    .dig_valid_i (dig_valid_i),
    .dig_ready_o (dig_ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .match_o     (match_o),
    .digest_o    (digest_o)
  );

  localparam logic [31:0]  MSG_ABCD = 32'h61626364;
  localparam logic [159:0] DIG_ABCD =
    160'h81FE8BFE_87576C3E_CB22426F_8E578473_82917ACF;
  localparam logic [159:0] DIG_BAD =
    160'h81FE8BFE_87576C3E_CB22426F_8E578473_82917ACE;
  localparam logic [159:0] DIG_ZERO =
    160'h9069CA78_E7450A28_5173431B_3E52C5C2_5299E473;

  typedef struct {
    logic         m;
    logic [159:0] d;
    int           e0;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_done = 0;
  int   last_e0 = 0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [191:0] act,
                     input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout", nm);
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (done_o) begin
      exp_t e;
      n_done++;
      chk("done_single_cycle", {191'd0, prev_done}, 192'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard");
      end else begin
        e = exp_q.pop_front();
        chk("match", {191'd0, match_o}, {191'd0, e.m});
        chk("digest", {32'd0, digest_o}, {32'd0, e.d});
        chk("latency", 192'(cyc - e.e0), 192'd81);
      end
    end
    prev_done = done_o;
  end

  task automatic send_msg(input logic [31:0] m);
    int n = 0;
    msg_i = m;
    msg_valid_i = 1'b1;
    @(negedge clk);
    while (!msg_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!msg_ready_o) fail_now("msg_ready_wait");
    @(posedge clk);
    #1 msg_valid_i = 1'b0;
  endtask

  task automatic send_digs(input logic [159:0] d, input int cnt,
                           input int gap);
    for (int i = 0; i < cnt; i++) begin
      int n = 0;
      dig_i = d[159-32*i -: 32];
      dig_valid_i = 1'b1;
      @(negedge clk);
      while (!dig_ready_o && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!dig_ready_o) fail_now("dig_ready_wait");
      @(posedge clk);
      #1 dig_valid_i = 1'b0;
      last_e0 = cyc;
      if (i != cnt - 1) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic push_exp(input logic m, input logic [159:0] d);
    exp_t e;
    e.m = m;
    e.d = d;
    e.e0 = last_e0;
    exp_q.push_back(e);
  endtask

  task automatic run_txn(input logic [31:0] m, input logic [159:0] dg,
                         input int gap, input logic em,
                         input logic [159:0] ed);
    send_msg(m);
    send_digs(dg, 5, gap);
    push_exp(em, ed);
  endtask

  task automatic wait_done();
    int start = n_done;
    int n = 0;
    while (n_done == start && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n_done == start) fail_now("wait_done");
    #1;
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    clear_i = 1'b0;
    msg_i = '0;
    msg_valid_i = 1'b0;
    dig_i = '0;
    dig_valid_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs",
        {27'd0, msg_ready_o, dig_ready_o, busy_o, done_o, match_o,
         digest_o}, 192'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {189'd0, msg_ready_o, dig_ready_o, busy_o},
        {189'd0, 3'b100});
    @(posedge clk);
    #1;

    // Match and mismatch on "abcd"
    run_txn(MSG_ABCD, DIG_ABCD, 0, 1'b1, DIG_ABCD);
    wait_done();
    run_txn(MSG_ABCD, DIG_BAD, 0, 1'b0, DIG_ABCD);
    wait_done();

    // Zero message, stalled digest words, stray word during ROUND
    run_txn(32'h0, DIG_ZERO, 1, 1'b1, DIG_ZERO);
    repeat (10) @(posedge clk);
    #1;
    dig_i = 32'hFFFFFFFF;
    dig_valid_i = 1'b1;
    @(negedge clk);
    chk("stray_ready", {191'd0, dig_ready_o}, 192'd0);
    @(posedge clk);
    #1 dig_valid_i = 1'b0;
    wait_done();

    // Abort at t=40
    send_msg(MSG_ABCD);
    send_digs(DIG_ABCD, 5, 0);
    nd = n_done;
    repeat (40) @(posedge clk);
    #1 clear_i = 1'b1;
    @(posedge clk);
    #1 clear_i = 1'b0;
    @(negedge clk);
    chk("after_clear", {189'd0, busy_o, msg_ready_o, match_o},
        {189'd0, 3'b010});
    repeat (60) @(posedge clk);
    #1;
    chk("abort_no_done", 192'(n_done - nd), 192'd0);
    run_txn(MSG_ABCD, DIG_ABCD, 0, 1'b1, DIG_ABCD);
    wait_done();

    // Reset during COLLECT after three words
    send_msg(32'h0);
    send_digs(DIG_ZERO, 3, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs",
        {27'd0, msg_ready_o, dig_ready_o, busy_o, done_o, match_o,
         digest_o}, 192'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_after",
        {29'd0, msg_ready_o, busy_o, match_o, digest_o},
        {29'd0, 3'b100, 160'd0});
    @(posedge clk);
    #1;

    // Back-to-back: 2nd message presented in the done cycle
    run_txn(MSG_ABCD, DIG_ABCD, 0, 1'b1, DIG_ABCD);
    begin
      int n = 0;
      @(negedge clk);
      while (!done_o && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!done_o) fail_now("b2b_done_wait");
    end
    msg_i = 32'h0;
    msg_valid_i = 1'b1;
    chk("b2b_ready", {191'd0, msg_ready_o}, {191'd0, 1'b1});
    @(posedge clk);
    #1 msg_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_cleared", {29'd0, busy_o, done_o, match_o, digest_o},
        {29'd0, 3'b100, 160'd0});
    @(posedge clk);
    #1;
    send_digs(DIG_ZERO, 5, 0);
    push_exp(1'b1, DIG_ZERO);
    wait_done();

    repeat (3) @(posedge clk);
    chk("sb_empty", 192'(exp_q.size()), 192'd0);
    chk("done_count", 192'(n_done), 192'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sha1_check.md
# sha1_check

Sequential SHA-1 verifier that consumes the 160-bit digest produced by the core's combinational SHA-1 unit. It recomputes the digest of a 32-bit message one round per cycle, then compares it against an expected digest streamed in as five 32-bit words. It sits on the peripheral side of the core as the checking end of the digest interface and reports pass/fail once per transaction.

## Interface
- No parameters. Padding and the round count are fixed: one 512-bit block, 80 rounds.
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- clear_i  in  1  synchronous abort; returns the block to IDLE
- msg_i  in  32  message word (4 bytes, big-endian)
- msg_valid_i  in  1  msg_i valid
- msg_ready_o  out  1  high only in IDLE
- dig_i  in  32  expected digest word; H0 first, H4 last
- dig_valid_i  in  1  dig_i valid
- dig_ready_o  out  1  high only in COLLECT
- busy_o  out  1  high in COLLECT and ROUND
- done_o  out  1  one-cycle completion pulse
- match_o  out  1  computed digest == expected digest; held until the next message is accepted
- digest_o  out  160  computed digest {H0..H4}; held until the next message is accepted

## Operation
- **States:**
  - IDLE: accepts a message.
  - COLLECT: takes in the 5 expected digest words.
  - ROUND: 80 cycles, round counter t = 0..79.
  - FIN: 1 cycle.
- **Transfer rule:** a transfer occurs on an edge where valid && ready are both high.
- **IDLE -> COLLECT** on the msg transfer:
  - latch msg_i;
  - clear match_o and digest_o;
  - word count = 0.
- **COLLECT:** each dig transfer stores the word into slot[count] and increments count. On the 5th transfer, go to ROUND with t = 0.
- **Initialisation on entering ROUND:**
  - A..E = 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0;
  - message window W[0..15] = {msg, 80000000, 0 x13, 00000020}.
- **ROUND, every cycle:**
  - T = rotl5(A) + f_t(B,C,D) + E + K_t + Wt (mod 2^32);
  - E = D; D = C; C = rotl30(B); B = A; A = T;
  - shift the window: new word = rotl1(W[t-3] ^ W[t-8] ^ W[t-14] ^ W[t-16]).
- **Round function and constant by t:**
  - t 0-19: f = Ch, K = 5A827999;
  - t 20-39: f = Parity, K = 6ED9EBA1;
  - t 40-59: f = Maj, K = 8F1BBCDC;
  - t 60-79: f = Parity, K = CA62C1D6.
- **Wt source:** for t < 16, Wt is the window head; for t >= 16, Wt is the freshly computed word. The implementation uses a single 16x32 shift register; no 80-entry W array.
- **ROUND -> FIN** after t = 79.
- **FIN:**
  - digest_o = {H0+A, H1+B, H2+C, H3+D, H4+E};
  - match_o = (digest_o == {slot0..slot4});
  - done_o = 1;
  - go to IDLE.
- **clear_i:**
  - In any state: next state IDLE, counters zeroed, no done_o, match_o = 0.
  - digest_o is left unchanged.
  - clear_i outranks a simultaneous msg or dig handshake; that handshake does not occur because ready is forced low.
- **Inputs outside their state:** dig_valid_i in IDLE or ROUND is ignored, with no transfer. msg_valid_i outside IDLE is ignored.

## Timing
- **Reset:** while rst is high, state = IDLE and every output is 0, including msg_ready_o and digest_o. In the first cycle with rst low, msg_ready_o = 1.
- **Ready signals:** msg_ready_o and dig_ready_o are decoded from the registered state only, with no combinational path from valid.
- **Latency:** let E0 be the edge of the 5th dig transfer.
  - Rounds execute on edges E0+1 .. E0+80.
  - The FIN edge is E0+81: done_o, digest_o and match_o become visible after it, and msg_ready_o = 1 in the same cycle.
  - done_o falls at E0+82.
- **Back-to-back:** a msg transfer in the done_o cycle is legal. It clears match_o and digest_o on that edge.
- **Digest words:** may arrive with arbitrary gaps. Minimum transaction is 1 + 5 + 80 + 1 = 87 edges.
- **Reset mid-ROUND:** behaves exactly like power-up; no done_o pulse.

## Test plan
- **Match, "abcd":** reset, msg 61626364, digest 81FE8BFE 87576C3E CB22426F 8E578473 82917ACF with no gaps -> done_o pulses exactly 81 edges after the 5th digest word; match_o = 1; digest_o = 81FE8BFE87576C3ECB22426F8E57847382917ACF.
- **Mismatch:** same as the match case but H4 = 82917ACE -> done_o pulses; match_o = 0; digest_o unchanged from the match case.
- **Zero message with stalls:** msg 00000000, digest 9069CA78 E7450A28 5173431B 3E52C5C2 5299E473, dig_valid_i toggled every other cycle, plus a dig_valid_i pulse asserted during ROUND -> match_o = 1; the stray word is ignored.
- **Abort:** clear_i at t = 40, then a fresh "abcd" transaction -> no done_o for the aborted run; the second run matches; busy_o is low for the cycle after clear.
- **Reset and back-to-back:** rst for 1 cycle during COLLECT (after 3 words) -> all outputs 0, msg_ready_o = 1 next cycle. Then two transactions with the 2nd msg presented in the done_o cycle -> accepted at that edge, match_o cleared, second result correct.
